turbo_qpp_buffer: RTL and testbench
===================================

# turbo_qpp_buffer

Upstream feeder for `turbo_encoder`. It captures one serial code block of K bits (K = 1056 or 6144, chosen per block), then replays it as the systematic stream `ck` alongside the QPP-interleaved stream `ckp`. It also generates the `data_valid`/`length` framing that the encoder expects. Interleaver addresses are computed incrementally with add/compare-subtract only; no multipliers are used.

## Interface
- `K_SHORT`, 1056, block length when `length`=0
- `K_LONG`, 6144, block length when `length`=1
- `F1_S` / `F2_S`, 17 / 66, QPP coefficients for K_SHORT
- `F1_L` / `F2_L`, 263 / 480, QPP coefficients for K_LONG
- `GAP_CYCLES`, 16, idle cycles after a block, reserved for encoder tail/flush
- `clock`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input bit qualifier
- `in_start`  in  1  marks the first bit of a block
- `in_bit`  in  1  code-block bit
- `in_length`  in  1  block size select; sampled only on a start beat
- `in_ready`  out  1  buffer accepts input
- `data_valid`  out  1  one-cycle frame pulse to the encoder
- `length`  out  1  latched size select to the encoder
- `ck`  out  1  systematic bit c(i)
- `ckp`  out  1  interleaved bit c(pi(i))
- `busy`  out  1  high in every state except IDLE

## Operation
- Storage: 6144x1 bit array; 13-bit write counter `wr`, read counter `i` and address register `pi`.
- Accepted beat: `in_valid & in_ready`. Beats presented while `in_ready`=0 are dropped.
- States:
  - IDLE:
    - An accepted beat with `in_start` writes `in_bit` to address 0, latches `in_length` (which selects K), sets wr=1, and moves to LOAD.
    - An accepted beat without `in_start` is ignored.
  - LOAD: each accepted beat writes address `wr` and increments `wr`. The beat that writes address K-1 moves to START. `in_start` during LOAD is treated as an ordinary data bit.
  - START (1 cycle): drive `data_valid`=1 and `length`=latched value; initialise i=0, pi=0, g=F1+F2; move to EMIT.
  - EMIT (K cycles): output `ck`=mem[i] and `ckp`=mem[pi]. Each cycle updates pi←(pi+g) mod K, g←(g+2·F2) mod K, and i←i+1. After i=K-1, move to GAP.
  - GAP: hold for GAP_CYCLES cycles, then return to IDLE.
- Modular arithmetic: both operands are < K, so each mod is one add followed by a conditional subtract of K. Use 14-bit intermediates.
- `length` holds its latched value from START until the next START.

## Timing
- Reset: state=IDLE, wr=i=pi=0. Outputs on reset: `in_ready`=1, `data_valid`=0, `length`=0, `ck`=0, `ckp`=0, `busy`=0. Memory contents are not cleared.
- `in_ready` is 1 in IDLE and LOAD and 0 in START, EMIT and GAP.
- START follows the cycle after the last input beat is accepted.
- Pairs (ck(i), ckp(i)) appear on the K consecutive cycles after the `data_valid` pulse, i.e. bit i is on the cycle START+1+i. `ck`/`ckp` are 0 outside EMIT.
- Block-to-block period: (K load beats, minimum) + 1 + K + GAP_CYCLES cycles.
- Gaps in `in_valid` during LOAD simply stall the load; there is no timeout.
- `rst` asserted in any state returns to IDLE on the next edge. A partially loaded or partially emitted block is discarded, and no further `data_valid` is produced for it.

## Configuration
- `TURBO_QPP_RESTART_EN` defined: during LOAD, an accepted beat with `in_start`=1 aborts the current block. That beat is written as bit 0, `in_length` is re-latched, and wr=1; the state stays LOAD.
- Not defined: `in_start` is ignored in LOAD, as described above.

## Test plan
- K=1056, single 1 loaded at index 83 (all other bits 0) -> `data_valid` one cycle after the last beat, `length`=0; `ckp`=1 only on EMIT cycle 1; `ck`=1 only on EMIT cycle 83.
- K=6144 (`in_length`=1), single 1 at index 2446 -> `length`=1; `ckp`=1 only on EMIT cycle 2; `ck`=1 only on cycle 2446.
- Wrap check: K=1056 with a 1 at index 49 -> `ckp`=1 on EMIT cycle 1055; K=6144 with a 1 at index 217 -> `ckp`=1 on EMIT cycle 6143.
- Back-to-back blocks with `in_valid` held high -> `in_ready`=0 for exactly 1+K+GAP_CYCLES cycles. Beats offered in that window are dropped, and the next block starts only on a beat with `in_start`.
- `rst` pulsed mid-EMIT (i=500) -> the next cycle shows `ck`=`ckp`=0, `busy`=0, `in_ready`=1, with no `data_valid`.
- With `TURBO_QPP_RESTART_EN`: `in_start` at wr=300, followed by a full 1056-bit block -> exactly one `data_valid`, and the emitted data equals the second block. Without the macro: `data_valid` occurs after 1056 total beats.

Source files
------------

// File: rtl/turbo_qpp_buffer.sv
// turbo_qpp_buffer: captures one K-bit block (K=1056/6144), then replays
// it as systematic ck and QPP-interleaved ckp with data_valid/length framing.
// Ports: clock, rst (sync, active-high); in_valid/in_start/in_bit/in_length
// -> in_ready; data_valid, length, ck, ckp, busy to the encoder.
// Macro TURBO_QPP_RESTART_EN: in_start during LOAD restarts the block.
module turbo_qpp_buffer #(
  parameter int K_SHORT    = 1056,
  parameter int K_LONG     = 6144,
  parameter int F1_S       = 17,
  parameter int F2_S       = 66,
  parameter int F1_L       = 263,
  parameter int F2_L       = 480,
  parameter int GAP_CYCLES = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic in_valid,
  input  logic in_start,
  input  logic in_bit,
  input  logic in_length,
  output logic in_ready,
  output logic data_valid,
  output logic length,
  output logic ck,
  output logic ckp,
  output logic busy
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_EMIT, S_GAP
  } state_e;

  state_e state_q, state_d;

  logic [12:0]   wr_q, wr_d;
  logic [12:0]   i_q, i_d;
  logic [12:0]   pi_q, pi_d;
  logic [12:0]   g_q, g_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          blen_q, blen_d;
  logic          len_q, len_d;

  logic mem_q [K_LONG];

  logic        acc;
  logic        restart;
  logic        we;
  logic [12:0] waddr;
  logic [12:0] k_cur, f1_cur, f2_cur;
  logic [13:0] pi_sum, g_sum;
  logic [12:0] pi_mod, g_mod;

  assign acc = in_valid & in_ready;

`ifdef TURBO_QPP_RESTART_EN
  assign restart = in_start;
`else
  assign restart = 1'b0;
`endif

  assign k_cur  = blen_q ? 13'(K_LONG) : 13'(K_SHORT);
  assign f1_cur = blen_q ? 13'(F1_L) : 13'(F1_S);
  assign f2_cur = blen_q ? 13'(F2_L) : 13'(F2_S);

  // Both operands are < K, so a single conditional subtract
  // brings each sum back into range.
  assign pi_sum = {1'b0, pi_q} + {1'b0, g_q};
  assign g_sum  = {1'b0, g_q} + {f2_cur, 1'b0};
  assign pi_mod = (pi_sum >= {1'b0, k_cur}) ?
                  13'(pi_sum - {1'b0, k_cur}) : pi_sum[12:0];
  assign g_mod  = (g_sum >= {1'b0, k_cur}) ?
                  13'(g_sum - {1'b0, k_cur}) : g_sum[12:0];

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    i_d     = i_q;
    pi_d    = pi_q;
    g_d     = g_q;
    gap_d   = gap_q;
    blen_d  = blen_q;
    len_d   = len_q;
    we      = 1'b0;
    waddr   = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc && in_start) begin
          we      = 1'b1;
          waddr   = '0;
          blen_d  = in_length;
          wr_d    = 13'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (acc && restart) begin
          we     = 1'b1;
          waddr  = '0;
          blen_d = in_length;
          wr_d   = 13'd1;
        end else if (acc) begin
          we    = 1'b1;
          waddr = wr_q;
          wr_d  = wr_q + 13'd1;
          if (wr_q == k_cur - 13'd1) begin
            state_d = S_START;
            len_d   = blen_q;
          end
        end
      end
      S_START: begin
        i_d     = '0;
        pi_d    = '0;
        g_d     = f1_cur + f2_cur;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        pi_d = pi_mod;
        g_d  = g_mod;
        i_d  = i_q + 13'd1;
        if (i_q == k_cur - 13'd1) begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      i_q     <= '0;
      pi_q    <= '0;
      g_q     <= '0;
      gap_q   <= '0;
      blen_q  <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      i_q     <= i_d;
      pi_q    <= pi_d;
      g_q     <= g_d;
      gap_q   <= gap_d;
      blen_q  <= blen_d;
      len_q   <= len_d;
    end
  end

  // Storage is never cleared; a reset only discards the block state.
  always_ff @(posedge clock) begin
    if (!rst && we) begin
      mem_q[waddr] <= in_bit;
    end
  end

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign data_valid = (state_q == S_START);
  assign length     = len_q;
  assign busy       = (state_q != S_IDLE);
  assign ck         = (state_q == S_EMIT) & mem_q[i_q];
  assign ckp        = (state_q == S_EMIT) & mem_q[pi_q];

endmodule

// File: tb/tb_turbo_qpp_buffer.sv
// tb_turbo_qpp_buffer: directed bench for turbo_qpp_buffer.
// Loads single-one blocks and checks framing and QPP positions.
module tb_turbo_qpp_buffer;

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_start = 1'b0;
  logic in_bit = 1'b0;
  logic in_length = 1'b0;
  logic in_ready, data_valid, length, ck, ckp, busy;

  int checks = 0;
  int errors = 0;

  turbo_qpp_buffer dut (
    .clock(clock),
    .rst(rst),
    .in_valid(in_valid),
    .in_start(in_start),
    .in_bit(in_bit),
    .in_length(in_length),
    .in_ready(in_ready),
    .data_valid(data_valid),
    .length(length),
    .ck(ck),
    .ckp(ckp),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load_block(input int k, input bit len,
                            input int one_at, input bit all1);
    for (int n = 0; n < k; n++) begin
      in_valid  = 1'b1;
      in_start  = (n == 0);
      in_length = len;
      in_bit    = all1 || (n == one_at);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    in_start = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic run_block(input int k, input bit len,
                           input int one_at, input int exp_ck,
                           input int exp_ckp, input bit hold);
    int lo, dvn, ckn, ckpn, ck_at, ckp_at, stray;
    lo = 0; dvn = 0; ckn = 0; ckpn = 0;
    ck_at = -1; ckp_at = -1; stray = 0;
    load_block(k, len, one_at, 1'b0);
    if (hold) begin
      in_valid = 1'b1;
      in_start = 1'b0;
      in_bit   = 1'b1;
    end
    @(negedge clock);
    while (!in_ready && lo < 8000) begin
      if (lo == 0) begin
        chk("dv_start", data_valid, 1);
        chk("length", length, len);
      end else if (lo <= k) begin
        if (ck) begin ckn++; ck_at = lo - 1; end
        if (ckp) begin ckpn++; ckp_at = lo - 1; end
      end
      if ((lo == 0 || lo > k) && (ck || ckp)) stray++;
      if (length != len) stray++;
      dvn += int'(data_valid);
      lo++;
      @(negedge clock);
    end
    chk("rdy_low", lo, 1 + k + 16);
    chk("dv_cnt", dvn, 1);
    chk("ck_n", ckn, 1);
    chk("ck_at", ck_at, exp_ck);
    chk("ckp_n", ckpn, 1);
    chk("ckp_at", ckp_at, exp_ckp);
    chk("stray", stray, 0);
    if (hold) begin
      repeat (3) @(negedge clock);
      chk("idle_ign", busy, 0);
      chk("idle_rdy", in_ready, 1);
      in_valid = 1'b0;
      in_bit   = 1'b0;
    end
  endtask

  initial begin
    int dvn, dv_c, ckn, bz;
    int cka [2];

    repeat (2) @(negedge clock);
    chk("rst_rdy", in_ready, 1);
    chk("rst_dv", data_valid, 0);
    chk("rst_len", length, 0);
    chk("rst_ck", ck, 0);
    chk("rst_ckp", ckp, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    run_block(1056, 1'b0, 83, 83, 1, 1'b1);
    run_block(6144, 1'b1, 2446, 2446, 2, 1'b0);
    run_block(1056, 1'b0, 49, 49, 1055, 1'b0);
    run_block(6144, 1'b1, 217, 217, 6143, 1'b0);

    load_block(1056, 1'b0, -1, 1'b1);
    @(negedge clock);
    chk("e_dv", data_valid, 1);
    repeat (501) @(negedge clock);
    chk("e_ck_pre", ck, 1);
    rst = 1'b1;
    @(negedge clock);
    chk("e_ck", ck, 0);
    chk("e_ckp", ckp, 0);
    chk("e_busy", busy, 0);
    chk("e_rdy", in_ready, 1);
    chk("e_dv0", data_valid, 0);
    rst = 1'b0;
    dvn = 0; bz = 0;
    repeat (1200) begin
      @(negedge clock);
      dvn += int'(data_valid);
      bz  += int'(busy);
    end
    chk("e_no_dv", dvn, 0);
    chk("e_no_busy", bz, 0);

    dvn = 0; dv_c = -1; ckn = 0;
    cka[0] = -1; cka[1] = -1;
    @(posedge clock); #1;
    fork
      begin
        for (int n = 0; n < 1356; n++) begin
          in_valid  = 1'b1;
          in_start  = (n == 0) || (n == 300);
          in_length = 1'b0;
          in_bit    = (n == 10) || (n == 383);
          @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_start = 1'b0;
        in_bit   = 1'b0;
      end
      begin
        for (int c = 0; c < 2500; c++) begin
          @(negedge clock);
          if (data_valid) begin
            dvn++;
            dv_c = c;
          end else if (dvn > 0 && ck) begin
            if (ckn < 2) cka[ckn] = c - dv_c - 1;
            ckn++;
          end
        end
      end
    join
    chk("r_dv_n", dvn, 1);
`ifdef TURBO_QPP_RESTART_EN
    chk("r_dv_at", dv_c, 1356);
    chk("r_ck_n", ckn, 1);
    chk("r_ck0", cka[0], 83);
`else
    chk("r_dv_at", dv_c, 1056);
    chk("r_ck_n", ckn, 2);
    chk("r_ck0", cka[0], 10);
    chk("r_ck1", cka[1], 383);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
